// File: rtl/traffic_pkg.sv
// Shared lamp codes, controller phase states and road indices for the
// four-road junction signal controller.
package traffic_pkg;

    localparam logic [1:0] LAMP_RED    = 2'd0;
    localparam logic [1:0] LAMP_GREEN  = 2'd1;
    localparam logic [1:0] LAMP_YELLOW = 2'd2;

    typedef enum logic [1:0] {
        S_ALL_RED = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2
    } phase_t;

    localparam logic [1:0] ROAD_A = 2'd0;
    localparam logic [1:0] ROAD_B = 2'd1;
    localparam logic [1:0] ROAD_C = 2'd2;
    localparam logic [1:0] ROAD_D = 2'd3;

endpackage

// File: rtl/phase_select.sv
// Combinational grant arbiter: emergency request first, then a starved road,
// then the busiest road, with ties always resolved toward the lowest index.
module phase_select
    import traffic_pkg::*;
#(
    parameter int MAX_SKIP = 3,
    parameter int SKIP_W   = $clog2(MAX_SKIP + 1)
) (
    input  logic [3:0][7:0]        count,
    input  logic [3:0][SKIP_W-1:0] skip,
    input  logic [3:0]             emerg,
    output logic [1:0]             winner,
    output logic                   any_demand
);

    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_SKIP);

    logic       forced_hit;
    logic       emerg_hit;
    logic [1:0] forced_idx;
    logic [1:0] emerg_idx;
    logic [1:0] best_idx;
    logic [7:0] best_cnt;

    always_comb begin
        forced_hit = 1'b0;
        forced_idx = ROAD_A;
        emerg_hit  = 1'b0;
        emerg_idx  = ROAD_A;
        best_idx   = ROAD_A;
        best_cnt   = count[0];
        any_demand = |emerg;
        // Scan downward so the lowest matching index is the one that sticks.
        for (int i = 3; i >= 0; i--) begin
            if (count[i] != 8'd0) begin
                any_demand = 1'b1;
                if (skip[i] == SKIP_MAX) begin
                    forced_hit = 1'b1;
                    forced_idx = 2'(i);
                end
            end
            if (emerg[i]) begin
                emerg_hit = 1'b1;
                emerg_idx = 2'(i);
            end
        end
        for (int i = 1; i < 4; i++) begin
            if (count[i] > best_cnt) begin
                best_cnt = count[i];
                best_idx = 2'(i);
            end
        end
        if (emerg_hit)
            winner = emerg_idx;
        else if (forced_hit)
            winner = forced_idx;
        else
            winner = best_idx;
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Junction phase controller: GREEN -> YELLOW -> ALL_RED per grant, registered lamps.
// Define EMERGENCY_OVERRIDE_EN to add the EmergReq pre-emption input.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = 20,
    parameter int MAX_GREEN   = 60,
    parameter int YELLOW_TIME = 5,
    parameter int ALLRED_TIME = 2,
    parameter int MAX_SKIP    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] CountA,
    input  logic [7:0] CountB,
    input  logic [7:0] CountC,
    input  logic [7:0] CountD,
`ifdef EMERGENCY_OVERRIDE_EN
    input  logic [3:0] EmergReq,
`endif
    output logic [1:0] LightA,
    output logic [1:0] LightB,
    output logic [1:0] LightC,
    output logic [1:0] LightD,
    output logic [1:0] GreenRoad,
    output logic       GreenValid,
    output logic       PhaseStart
);

    // The timer must also reach the yellow and clearance limits if those exceed MAX_GREEN.
    localparam int ELAP_TOP0 = (MAX_GREEN > YELLOW_TIME) ? MAX_GREEN : YELLOW_TIME;
    localparam int ELAP_TOP  = ((ELAP_TOP0 > ALLRED_TIME) ? ELAP_TOP0 : ALLRED_TIME) - 1;
    localparam int ELAP_W    = $clog2(ELAP_TOP + 2);
    localparam int SKIP_W    = $clog2(MAX_SKIP + 1);

    localparam logic [ELAP_W-1:0] ELAP_LAST  = ELAP_W'(ELAP_TOP);
    localparam logic [ELAP_W-1:0] MIN_LAST   = ELAP_W'(MIN_GREEN - 1);
    localparam logic [ELAP_W-1:0] GREEN_LAST = ELAP_W'(MAX_GREEN - 1);
    localparam logic [ELAP_W-1:0] YEL_LAST   = ELAP_W'(YELLOW_TIME - 1);
    localparam logic [ELAP_W-1:0] AR_LAST    = ELAP_W'(ALLRED_TIME - 1);
    localparam logic [SKIP_W-1:0] SKIP_MAX   = SKIP_W'(MAX_SKIP);

    function automatic logic [ELAP_W-1:0] elap_inc(input logic [ELAP_W-1:0] v);
        return (v == ELAP_LAST) ? v : v + ELAP_W'(1);
    endfunction

    function automatic logic [SKIP_W-1:0] skip_inc(input logic [SKIP_W-1:0] v);
        return (v == SKIP_MAX) ? v : v + SKIP_W'(1);
    endfunction

    logic [3:0][7:0]        count;
    logic [3:0]             emerg;
    phase_t                 state, state_n;
    logic [ELAP_W-1:0]      elap, elap_n;
    logic [1:0]             served, served_n;
    logic [3:0][SKIP_W-1:0] skip, skip_n;
    logic [3:0][1:0]        light, light_n;
    logic [1:0]             road_n;
    logic                   valid_n;
    logic                   start_n;
    logic                   rival;
    logic [1:0]             winner;
    logic                   any_demand;

    assign count = {CountD, CountC, CountB, CountA};

`ifdef EMERGENCY_OVERRIDE_EN
    assign emerg = EmergReq;
`else
    assign emerg = 4'b0000;
`endif

    phase_select #(
        .MAX_SKIP (MAX_SKIP),
        .SKIP_W   (SKIP_W)
    ) u_phase_select (
        .count      (count),
        .skip       (skip),
        .emerg      (emerg),
        .winner     (winner),
        .any_demand (any_demand)
    );

    always_comb begin
        state_n  = state;
        elap_n   = elap_inc(elap);
        served_n = served;
        skip_n   = skip;
        start_n  = 1'b0;
        rival    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) != served && count[i] != 8'd0)
                rival = 1'b1;
        end

        unique case (state)
            S_ALL_RED: begin
                if (elap == AR_LAST) begin
                    if (any_demand) begin
                        state_n  = S_GREEN;
                        elap_n   = '0;
                        served_n = winner;
                        start_n  = 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            if (2'(i) == winner)
                                skip_n[i] = '0;
                            else if (count[i] != 8'd0)
                                skip_n[i] = skip_inc(skip[i]);
                        end
                    end else begin
                        elap_n = elap;
                    end
                end
            end
            S_GREEN: begin
                // A road holding its own emergency request is never pushed out.
                if (!emerg[served] &&
                    ((|emerg) ||
                     (elap >= MIN_LAST && count[served] == 8'd0) ||
                     (elap >= GREEN_LAST && rival))) begin
                    state_n = S_YELLOW;
                    elap_n  = '0;
                end
            end
            S_YELLOW: begin
                if (elap == YEL_LAST) begin
                    state_n = S_ALL_RED;
                    elap_n  = '0;
                end
            end
            default: begin
                state_n = S_ALL_RED;
                elap_n  = '0;
            end
        endcase

        light_n = {4{LAMP_RED}};
        if (state_n == S_GREEN)
            light_n[served_n] = LAMP_GREEN;
        else if (state_n == S_YELLOW)
            light_n[served_n] = LAMP_YELLOW;
        valid_n = (state_n != S_ALL_RED);
        road_n  = valid_n ? served_n : ROAD_A;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_ALL_RED;
            elap       <= '0;
            served     <= ROAD_A;
            skip       <= '0;
            light      <= {4{LAMP_RED}};
            GreenRoad  <= ROAD_A;
            GreenValid <= 1'b0;
            PhaseStart <= 1'b0;
        end else begin
            state      <= state_n;
            elap       <= elap_n;
            served     <= served_n;
            skip       <= skip_n;
            light      <= light_n;
            GreenRoad  <= road_n;
            GreenValid <= valid_n;
            PhaseStart <= start_n;
        end
    end

    assign LightA = light[0];
    assign LightB = light[1];
    assign LightC = light[2];
    assign LightD = light[3];

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random occupancy traffic
// checked each cycle against a rule-level model of the junction controller.
module tb_traffic_phase_scheduler;

    localparam int MIN_G = 4;
    localparam int MAX_G = 8;
    localparam int YEL   = 2;
    localparam int AR    = 2;
    localparam int MSKIP = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] CountA = 8'd0, CountB = 8'd0, CountC = 8'd0, CountD = 8'd0;
    logic [3:0] emerg_req = 4'b0000;
    logic [1:0] LightA, LightB, LightC, LightD, GreenRoad;
    logic       GreenValid, PhaseStart;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .MIN_GREEN   (MIN_G),
        .MAX_GREEN   (MAX_G),
        .YELLOW_TIME (YEL),
        .ALLRED_TIME (AR),
        .MAX_SKIP    (MSKIP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .CountA     (CountA),
        .CountB     (CountB),
        .CountC     (CountC),
        .CountD     (CountD),
`ifdef EMERGENCY_OVERRIDE_EN
        .EmergReq   (emerg_req),
`endif
        .LightA     (LightA),
        .LightB     (LightB),
        .LightC     (LightC),
        .LightD     (LightD),
        .GreenRoad  (GreenRoad),
        .GreenValid (GreenValid),
        .PhaseStart (PhaseStart)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    // Model: mode 0 = clearance, 1 = green, 2 = yellow; t = cycles already spent in mode.
    int m_mode, m_t, m_road;
    int m_skip[4];
    int grants[$];
    int grant_cyc[$];
    int glen[$];

    function automatic int cnt_of(input int r);
        case (r)
            0: return int'(CountA);
            1: return int'(CountB);
            2: return int'(CountC);
            default: return int'(CountD);
        endcase
    endfunction

    function automatic int choose();
        int best;
        for (int r = 0; r < 4; r++) if (emerg_req[r]) return r;
        for (int r = 0; r < 4; r++) if (cnt_of(r) > 0 && m_skip[r] >= MSKIP) return r;
        best = 0;
        for (int r = 1; r < 4; r++) if (cnt_of(r) > cnt_of(best)) best = r;
        return best;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_t    = 0;
        m_road = 0;
        for (int r = 0; r < 4; r++) m_skip[r] = 0;
    endtask

    task automatic model_step();
        bit demand, others, leave;
        int win;
        case (m_mode)
            0: begin
                demand = (emerg_req != 4'b0000);
                for (int r = 0; r < 4; r++) if (cnt_of(r) > 0) demand = 1'b1;
                if (m_t >= AR - 1 && demand) begin
                    win = choose();
                    for (int r = 0; r < 4; r++) begin
                        if (r == win) m_skip[r] = 0;
                        else if (cnt_of(r) > 0 && m_skip[r] < MSKIP) m_skip[r]++;
                    end
                    m_mode = 1; m_t = 0; m_road = win;
                end else begin
                    m_t++;
                end
            end
            1: begin
                others = 1'b0;
                for (int r = 0; r < 4; r++) if (r != m_road && cnt_of(r) > 0) others = 1'b1;
                if (emerg_req[m_road]) leave = 1'b0;
                else if (emerg_req != 4'b0000) leave = 1'b1;
                else leave = (m_t >= MIN_G - 1 && cnt_of(m_road) == 0) || (m_t >= MAX_G - 1 && others);
                if (leave) begin m_mode = 2; m_t = 0; end
                else m_t++;
            end
            default: begin
                if (m_t >= YEL - 1) begin m_mode = 0; m_t = 0; end
                else m_t++;
            end
        endcase
    endtask

    task automatic compare();
        logic [7:0] exp_l, act_l;
        bit exp_v, exp_ps, ok;
        exp_l = 8'h00;
        if (m_mode == 1) exp_l[2*m_road +: 2] = 2'd1;
        else if (m_mode == 2) exp_l[2*m_road +: 2] = 2'd2;
        exp_v  = (m_mode != 0);
        exp_ps = (m_mode == 1 && m_t == 0);
        act_l  = {LightD, LightC, LightB, LightA};
        ok = (act_l == exp_l) && (GreenValid == exp_v) && (PhaseStart == exp_ps) &&
             (!exp_v || GreenRoad == 2'(m_road));
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL outputs cyc=%0d: got lights=%h valid=%b road=%0d start=%b, need lights=%h valid=%b road=%0d start=%b",
                     cyc, act_l, GreenValid, GreenRoad, PhaseStart, exp_l, exp_v, m_road, exp_ps);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        cyc++;
        compare();
        if (PhaseStart) begin
            grants.push_back(int'(GreenRoad));
            grant_cyc.push_back(cyc);
            glen.push_back(1);
        end else if (glen.size() > 0 &&
                     (LightA == 2'd1 || LightB == 2'd1 || LightC == 2'd1 || LightD == 2'd1)) begin
            glen[glen.size()-1]++;
        end
    endtask

    task automatic release_reset();
        reset = 1'b0;
        cyc = 0;
        grants.delete();
        grant_cyc.delete();
        glen.delete();
    endtask

    task automatic start_run(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        reset = 1'b1;
        CountA = a; CountB = b; CountC = c; CountD = d;
        emerg_req = 4'b0000;
        #1;
        model_reset();
        compare();
        check("reset_state", int'({LightD, LightC, LightB, LightA, GreenValid, PhaseStart}), 0);
        tick();
        release_reset();
    endtask

    task automatic set_road(input int r, input logic [7:0] v);
        case (r)
            0: CountA = v;
            1: CountB = v;
            2: CountC = v;
            default: CountD = v;
        endcase
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Idle junction stays all red
        start_run(8'd0, 8'd0, 8'd0, 8'd0);
        repeat (50) tick();
        check("idle_grants", grants.size(), 0);
        check("idle_lights", int'({LightD, LightC, LightB, LightA}), 0);

        // Lone road B, no rivals
        start_run(8'd0, 8'd5, 8'd0, 8'd0);
        repeat (2) tick();
        check("b_green_at_2", int'(LightB), 1);
        check("b_phase_start", int'(PhaseStart), 1);
        repeat (10) tick();
        check("b_held_at_12", int'(LightB), 1);
        CountB = 8'd0;
        tick();
        check("b_yellow_13", int'(LightB), 2);
        repeat (2) tick();
        check("b_red_15", int'(LightB), 0);
        check("b_one_grant", grants.size(), 1);

        // A and C tie; A wins twice, then C is forced by its skip count
        start_run(8'd3, 8'd0, 8'd3, 8'd0);
        repeat (30) tick();
        check("tie_grants", grants.size(), 3);
        check("tie_g0", grants[0], 0);
        check("tie_g1", grants[1], 0);
        check("tie_g2", grants[2], 2);
        check("tie_green_len", glen[0], 8);
        check("tie_spacing", grant_cyc[1] - grant_cyc[0], 12);

        // Heavy D versus light A: D, D, forced A, D
        start_run(8'd1, 8'd0, 8'd0, 8'd200);
        repeat (45) tick();
        check("skip_grants", grants.size(), 4);
        check("skip_g0", grants[0], 3);
        check("skip_g1", grants[1], 3);
        check("skip_g2", grants[2], 0);
        check("skip_g3", grants[3], 3);

        // Demand vanishes early: green still honours the minimum
        start_run(8'd5, 8'd0, 8'd0, 8'd0);
        repeat (3) tick();
        CountA = 8'd0;
        repeat (6) tick();
        check("min_green_len", glen[0], 4);
        check("min_red_after", int'(LightA), 0);

        // Async reset during yellow, then restart with cleared skips
        start_run(8'd1, 8'd0, 8'd0, 8'd200);
        repeat (22) tick();
        check("rst_in_yellow", int'(LightD), 2);
        reset = 1'b1;
        #1;
        check("rst_async_red", int'({LightD, LightC, LightB, LightA, GreenValid}), 0);
        model_reset();
        compare();
        repeat (2) tick();
        release_reset();
        repeat (2) tick();
        check("rst_restart_road", int'(GreenRoad), 3);
        check("rst_restart_green", int'(LightD), 1);

`ifdef EMERGENCY_OVERRIDE_EN
        // Emergency pre-emption of A by D
        start_run(8'd5, 8'd0, 8'd0, 8'd0);
        repeat (3) tick();
        emerg_req = 4'b1000;
        tick();
        check("emg_a_yellow", int'(LightA), 2);
        repeat (4) tick();
        check("emg_d_green", int'(LightD), 1);
        repeat (10) tick();
        check("emg_d_held", int'(LightD), 1);
        emerg_req = 4'b0000;
`endif

        // Random occupancy traffic with occasional async resets
        start_run(8'd0, 8'd0, 8'd0, 8'd0);
        for (int n = 0; n < 2000; n++) begin
            tick();
            if ($urandom_range(5) == 0) begin
                case ($urandom_range(3))
                    0: set_road(int'($urandom_range(3)), 8'd0);
                    1: set_road(int'($urandom_range(3)), 8'd1);
                    2: set_road(int'($urandom_range(3)), 8'($urandom_range(255)));
                    default: set_road(int'($urandom_range(3)), 8'd255);
                endcase
            end
`ifdef EMERGENCY_OVERRIDE_EN
            if ($urandom_range(60) == 0)
                emerg_req = ($urandom_range(1) == 0) ? 4'b0000 : 4'(1 << $urandom_range(3));
`endif
            if ($urandom_range(400) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                compare();
                tick();
                release_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
